rng_arbiter: RTL

RNG_ARBITER -- requirements
Module: rng_arbiter

---
 rtl/rng_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin arbiter handing out bounded random values
// drawn from a shared 4-bit LFSR, with rejection sampling and fallback.
module rng_arbiter #(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rand_in,
  input  logic [3:0]  req,
  input  logic [15:0] bound,
  output logic [3:0]  grant,
  output logic [3:0]  value,
  output logic        valid,
  output logic        fail,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] bnd_q, bnd_d;
  logic [3:0] try_q, try_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       fail_q, fail_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] cand;

  // Round-robin pick: scan last+1 .. last+4 (== last), first high wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + k[1:0];
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic for IDLE/DRAW/DONE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    bnd_d   = bnd_q;
    try_d   = try_q;
    grant_d = 4'b0000;
    valid_d = 1'b0;
    fail_d  = 1'b0;
    value_d = value_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          bnd_d   = bound[{pick_idx, 2'b00} +: 4];
          try_d   = 4'd0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (!req[idx_q]) begin
          // withdrawn: drop silently, round-robin pointer untouched
          state_d = IDLE;
        end else if (rand_in <= bnd_q) begin
          value_d = rand_in;
          valid_d = 1'b1;
          grant_d = 4'b0001 << idx_q;
          last_d  = idx_q;
          state_d = DONE;
        end else if (try_q == TRY_LAST) begin
          value_d = 4'd0;
          fail_d  = 1'b1;
          valid_d = 1'b1;
          grant_d = 4'b0001 << idx_q;
          last_d  = idx_q;
          state_d = DONE;
        end else begin
          try_d = try_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset beats every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      idx_q   <= 2'd0;
      bnd_q   <= 4'd0;
      try_q   <= 4'd0;
      grant_q <= 4'b0000;
      value_q <= 4'd0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      bnd_q   <= bnd_d;
      try_q   <= try_d;
      grant_q <= grant_d;
      value_q <= value_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
    end
  end

  assign grant = grant_q;
  assign value = value_q;
  assign valid = valid_q;
  assign fail  = fail_q;
  assign busy  = (state_q != IDLE);

endmodule
